// File: rtl/pixel_scanner.sv
// pixel_scanner: raster frame sequencer that drives the point generator and
// writes one mapped colour per pixel into the frame buffer, honouring backpressure.
`default_nettype none
`timescale 1ns/1ps

module pixel_scanner #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int HBI    = 32,
  parameter int ADDR_W = 19
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              go,
  input  logic [HBI-1:0]    max_iterations,
  output logic              busy,
  output logic              frame_done,
  output logic [11:0]       x,
  output logic [11:0]       y,
  output logic              pg_start,
  input  logic              pg_ready,
  input  logic [HBI-1:0]    pg_iteration,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              fb_we,
  input  logic              fb_full
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_GUARD = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [11:0]    X_LAST   = 12'(WIDTH - 1);
  localparam logic [11:0]    Y_LAST   = 12'(HEIGHT - 1);
  localparam logic [HBI-1:0] ITER_255 = HBI'(255);

  state_t state;
  state_t state_nxt;

  logic       accept;
  logic       last_x;
  logic       last_y;
  logic [7:0] colour;

  assign accept = (state == S_WRITE) && !fb_full;
  assign last_x = (x == X_LAST);
  assign last_y = (y == Y_LAST);

  always_comb begin
    colour = pg_iteration[7:0];
    if (pg_iteration >= max_iterations) begin
      colour = 8'h00;
    end else if (pg_iteration > ITER_255) begin
      colour = 8'hFF;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    pg_start   = 1'b0;
    frame_done = 1'b0;
    fb_we      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (go) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        pg_start  = 1'b1;
        state_nxt = S_GUARD;
      end
      // The generator's ready is still high from the previous pixel here.
      S_GUARD: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (pg_ready) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        fb_we = !fb_full;
        if (accept) begin
          state_nxt = (last_x && last_y) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Address tracks y*WIDTH+x by counting, so no multiplier is needed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x       <= '0;
      y       <= '0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      if (state == S_IDLE && go) begin
        x       <= '0;
        y       <= '0;
        fb_addr <= '0;
      end else if (accept && !(last_x && last_y)) begin
        fb_addr <= fb_addr + 1'b1;
        if (last_x) begin
          x <= '0;
          y <= y + 12'd1;
        end else begin
          x <= x + 12'd1;
        end
      end
      if (state == S_WAIT && pg_ready) begin
        fb_data <= colour;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pixel_scanner.sv
// tb_pixel_scanner: randomized self-checking bench for pixel_scanner (4x2 frame, stub generator).
`default_nettype none
`timescale 1ns/1ps

module tb_pixel_scanner;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int AW = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          go = 1'b0;
  logic [31:0]   max_iterations = 32'd100;
  logic          busy, frame_done, pg_start, fb_we;
  logic [11:0]   x, y;
  logic          pg_ready;
  logic [31:0]   pg_iteration;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data;
  logic          fb_full = 1'b0;

  int checks = 0;
  int failures = 0;

  pixel_scanner #(.WIDTH(W), .HEIGHT(H), .HBI(32), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .go(go), .max_iterations(max_iterations),
    .busy(busy), .frame_done(frame_done), .x(x), .y(y),
    .pg_start(pg_start), .pg_ready(pg_ready), .pg_iteration(pg_iteration),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_full(fb_full)
  );

  always #5 CLK = ~CLK;

  // Stub generator: ready drops after start, returns after lat cycles.
  logic [31:0] iter_tab [N];
  int          lat = 1;
  int          stub_cnt;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      pg_ready     <= 1'b1;
      stub_cnt     <= 0;
      pg_iteration <= '0;
    end else if (pg_start) begin
      pg_ready     <= 1'b0;
      stub_cnt     <= lat;
      pg_iteration <= iter_tab[(int'(y) * W + int'(x)) % N];
    end else if (!pg_ready) begin
      if (stub_cnt <= 1) pg_ready <= 1'b1;
      else stub_cnt <= stub_cnt - 1;
    end
  end

  // Monitor, sampled on the falling edge.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [AW-1:0] wr_addr [$];
  logic [7:0]    wr_data [$];
  logic [11:0]   wr_x [$];
  logic [11:0]   wr_y [$];
  int            wr_cyc [$];
  logic [AW-1:0] hold_addr [$];
  logic [7:0]    hold_data [$];
  int done_cnt = 0, start_cnt = 0, stab_err = 0, viol = 0;
  bit inpix = 0;
  logic [11:0] hx, hy;

  always @(negedge CLK) begin
    if (fb_we) begin
      wr_addr.push_back(fb_addr);
      wr_data.push_back(fb_data);
      wr_x.push_back(x);
      wr_y.push_back(y);
      wr_cyc.push_back(cyc);
    end
    if (fb_full && fb_we) viol++;
    if (fb_full && busy) begin
      hold_addr.push_back(fb_addr);
      hold_data.push_back(fb_data);
    end
    if (frame_done) done_cnt++;
    if (pg_start) begin
      start_cnt++;
      hx = x;
      hy = y;
      inpix = 1;
    end else if (inpix && (x != hx || y != hy)) begin
      stab_err++;
    end
    if (fb_we) inpix = 0;
  end

  function automatic logic [7:0] model_colour(input logic [31:0] it, input logic [31:0] mx);
    if (it >= mx) return 8'h00;
    if (it > 32'd255) return 8'hFF;
    return it[7:0];
  endfunction

  task automatic clear_mon();
    wr_addr.delete(); wr_data.delete(); wr_x.delete(); wr_y.delete(); wr_cyc.delete();
    hold_addr.delete(); hold_data.delete();
    done_cnt = 0; start_cnt = 0; stab_err = 0; viol = 0; inpix = 0;
  endtask

  // mode: 0 no backpressure, 1 random fb_full, 2 fb_full for 3 cycles at addr 2
  task automatic run_frame(input int mode, input bit go_mid, input int abort_addr,
                           output bit timeout, output bit aborted, output bit busy_after_go);
    int hold = 0;
    bit used = 0;
    timeout = 1;
    aborted = 0;
    clear_mon();
    @(posedge CLK); #1;
    go = 1'b1;
    @(posedge CLK); #1;
    go = 1'b0;
    busy_after_go = busy;
    for (int c = 0; c < 2000; c++) begin
      @(posedge CLK); #1;
      go = 1'b0;
      if (mode == 1) begin
        fb_full = ($urandom_range(0, 2) == 0);
      end else if (mode == 2) begin
        if (hold > 0) begin
          fb_full = 1'b1;
          hold--;
        end else if (!used && fb_we && fb_addr == 3'd2) begin
          fb_full = 1'b1;
          hold = 2;
          used = 1;
        end else begin
          fb_full = 1'b0;
        end
      end
      if (go_mid && c == 10) go = 1'b1;
      if (abort_addr >= 0 && fb_we && int'(fb_addr) == abort_addr) begin
        RST = 1'b1;
        #2;
        RST = 1'b0;
        aborted = 1;
        timeout = 0;
        break;
      end
      if (done_cnt > 0) begin
        timeout = 0;
        break;
      end
    end
    fb_full = 1'b0;
    go = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({busy, frame_done, pg_start, fb_we} !== 4'b0 || x !== 12'd0 || y !== 12'd0 ||
        fb_addr !== '0 || fb_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_initial: busy=%b x=%0d y=%0d addr=%0d data=%h, expected all 0",
               busy, x, y, fb_addr, fb_data);
    end
    RST = 1'b0;
    for (int i = 0; i < N; i++) iter_tab[i] = 32'd5;
    lat = 1;
    max_iterations = 32'd100;
    @(posedge CLK); #1;
    go = 1'b1;
    @(posedge CLK); #1;
    go = 1'b0;
    repeat (6) @(posedge CLK);
    #3;
    checks++;
    if (busy !== 1'b1 || x !== 12'd1 || fb_addr !== 3'd1 || fb_data !== 8'h05) begin
      failures++;
      $display("FAIL reset_premise: busy=%b x=%0d addr=%0d data=%h, expected 1/1/1/05",
               busy, x, fb_addr, fb_data);
    end
    RST = 1'b1;
    #1;
    checks++;
    if ({busy, frame_done, pg_start, fb_we} !== 4'b0 || x !== 12'd0 || y !== 12'd0 ||
        fb_addr !== '0 || fb_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_async: busy=%b x=%0d y=%0d addr=%0d data=%h, expected all 0",
               busy, x, y, fb_addr, fb_data);
    end
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_basic();
    bit to, ab, bg;
    for (int i = 0; i < N; i++) iter_tab[i] = 32'd5;
    max_iterations = 32'd100;
    lat = 1;
    run_frame(0, 0, -1, to, ab, bg);
    checks++;
    if (to || bg !== 1'b1) begin
      failures++;
      $display("FAIL basic_start: timeout=%0d busy_after_go=%b, expected 0/1", to, bg);
    end
    checks++;
    if (wr_addr.size() != N || done_cnt != 1 || start_cnt != N) begin
      failures++;
      $display("FAIL basic_counts: writes=%0d done=%0d starts=%0d, expected %0d/1/%0d",
               wr_addr.size(), done_cnt, start_cnt, N, N);
    end
    for (int i = 0; i < wr_addr.size() && i < N; i++) begin
      checks++;
      if (int'(wr_addr[i]) != i || wr_data[i] !== 8'h05 ||
          int'(wr_x[i]) != i % W || int'(wr_y[i]) != i / W) begin
        failures++;
        $display("FAIL basic_write%0d: addr=%0d data=%h x=%0d y=%0d, expected %0d/05/%0d/%0d",
                 i, wr_addr[i], wr_data[i], wr_x[i], wr_y[i], i, i % W, i / W);
      end
      if (i > 0) begin
        checks++;
        if (wr_cyc[i] - wr_cyc[i-1] != 4) begin
          failures++;
          $display("FAIL basic_spacing%0d: got %0d cycles, expected 4", i, wr_cyc[i] - wr_cyc[i-1]);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_colour();
    bit to, ab, bg;
    logic [31:0] mx;
    for (int f = 0; f < 2; f++) begin
      mx = (f == 0) ? 32'd100 : 32'd1000;
      max_iterations = mx;
      if (f == 0) begin
        iter_tab[0] = 32'd100; iter_tab[1] = 32'd99;  iter_tab[2] = 32'd0;  iter_tab[3] = 32'd255;
        iter_tab[4] = 32'd256; iter_tab[5] = $urandom_range(0, 99);
      end else begin
        iter_tab[0] = 32'd300; iter_tab[1] = 32'd255; iter_tab[2] = 32'd256; iter_tab[3] = 32'd999;
        iter_tab[4] = 32'd1000; iter_tab[5] = $urandom_range(0, 255);
      end
      iter_tab[6] = $urandom_range(0, 1200);
      iter_tab[7] = $urandom;
      lat = $urandom_range(1, 4);
      run_frame(0, 0, -1, to, ab, bg);
      checks++;
      if (to || wr_data.size() != N) begin
        failures++;
        $display("FAIL colour_frame%0d: timeout=%0d writes=%0d, expected 0/%0d", f, to, wr_data.size(), N);
      end
      for (int i = 0; i < wr_data.size() && i < N; i++) begin
        checks++;
        if (wr_data[i] !== model_colour(iter_tab[i], mx)) begin
          failures++;
          $display("FAIL colour%0d_%0d: iter=%0d max=%0d data=%h, expected %h", f, i,
                   iter_tab[i], mx, wr_data[i], model_colour(iter_tab[i], mx));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit to, ab, bg;
    int n2;
    max_iterations = 32'd500;
    for (int i = 0; i < N; i++) iter_tab[i] = $urandom_range(0, 600);
    lat = 1;
    run_frame(2, 0, -1, to, ab, bg);
    n2 = 0;
    foreach (wr_addr[i]) if (wr_addr[i] == 3'd2) n2++;
    checks++;
    if (to || wr_addr.size() != N || n2 != 1 || viol != 0) begin
      failures++;
      $display("FAIL bp_counts: timeout=%0d writes=%0d at2=%0d we_while_full=%0d, expected 0/%0d/1/0",
               to, wr_addr.size(), n2, viol, N);
    end
    checks++;
    if (hold_addr.size() != 3) begin
      failures++;
      $display("FAIL bp_stall_len: full cycles seen=%0d, expected 3", hold_addr.size());
    end
    foreach (hold_addr[i]) begin
      checks++;
      if (hold_addr[i] !== 3'd2 || hold_data[i] !== model_colour(iter_tab[2], 32'd500)) begin
        failures++;
        $display("FAIL bp_hold%0d: addr=%0d data=%h, expected 2/%h", i, hold_addr[i], hold_data[i],
                 model_colour(iter_tab[2], 32'd500));
      end
    end
    for (int i = 0; i < wr_addr.size() && i < N; i++) begin
      checks++;
      if (int'(wr_addr[i]) != i || wr_data[i] !== model_colour(iter_tab[i], 32'd500)) begin
        failures++;
        $display("FAIL bp_write%0d: addr=%0d data=%h, expected %0d/%h", i, wr_addr[i], wr_data[i],
                 i, model_colour(iter_tab[i], 32'd500));
      end
    end
  endtask

  task automatic test_stall_go();
    bit to, ab, bg;
    for (int i = 0; i < N; i++) iter_tab[i] = $urandom_range(0, 150);
    max_iterations = 32'd120;
    lat = 20;
    run_frame(0, 1, -1, to, ab, bg);
    checks++;
    if (to || start_cnt != N || stab_err != 0 || done_cnt != 1 || wr_addr.size() != N) begin
      failures++;
      $display("FAIL stall: timeout=%0d starts=%0d xy_changes=%0d done=%0d writes=%0d, expected 0/%0d/0/1/%0d",
               to, start_cnt, stab_err, done_cnt, wr_addr.size(), N, N);
    end
    repeat (20) @(posedge CLK);
    #1;
    checks++;
    if (busy !== 1'b0 || start_cnt != N || done_cnt != 1) begin
      failures++;
      $display("FAIL stall_no_restart: busy=%b starts=%0d done=%0d, expected 0/%0d/1", busy, start_cnt, done_cnt, N);
    end
  endtask

  task automatic test_reset_abort();
    bit to, ab, bg;
    for (int i = 0; i < N; i++) iter_tab[i] = $urandom_range(0, 300);
    max_iterations = 32'd256;
    lat = 1;
    run_frame(0, 0, 3, to, ab, bg);
    checks++;
    if (!ab || done_cnt != 0 || busy !== 1'b0 || fb_addr !== 3'd0 || wr_addr.size() != 3) begin
      failures++;
      $display("FAIL abort: aborted=%0d done=%0d busy=%b addr=%0d writes=%0d, expected 1/0/0/0/3",
               ab, done_cnt, busy, fb_addr, wr_addr.size());
    end
    run_frame(0, 0, -1, to, ab, bg);
    checks++;
    if (to || done_cnt != 1 || wr_addr.size() != N) begin
      failures++;
      $display("FAIL abort_restart: timeout=%0d done=%0d writes=%0d, expected 0/1/%0d", to, done_cnt, wr_addr.size(), N);
    end
    for (int i = 0; i < wr_addr.size() && i < N; i++) begin
      checks++;
      if (int'(wr_addr[i]) != i || wr_data[i] !== model_colour(iter_tab[i], 32'd256)) begin
        failures++;
        $display("FAIL abort_write%0d: addr=%0d data=%h, expected %0d/%h", i, wr_addr[i], wr_data[i],
                 i, model_colour(iter_tab[i], 32'd256));
      end
    end
  endtask

  task automatic test_random();
    bit to, ab, bg;
    logic [31:0] mx;
    for (int f = 0; f < 3; f++) begin
      mx = $urandom_range(1, 600);
      max_iterations = mx;
      for (int i = 0; i < N; i++) iter_tab[i] = $urandom_range(0, 700);
      lat = $urandom_range(1, 6);
      run_frame(1, 0, -1, to, ab, bg);
      checks++;
      if (to || done_cnt != 1 || wr_addr.size() != N || viol != 0 || stab_err != 0) begin
        failures++;
        $display("FAIL rand%0d_counts: timeout=%0d done=%0d writes=%0d we_while_full=%0d xy_changes=%0d",
                 f, to, done_cnt, wr_addr.size(), viol, stab_err);
      end
      for (int i = 0; i < wr_addr.size() && i < N; i++) begin
        checks++;
        if (int'(wr_addr[i]) != i || wr_data[i] !== model_colour(iter_tab[i], mx) ||
            int'(wr_x[i]) != i % W || int'(wr_y[i]) != i / W) begin
          failures++;
          $display("FAIL rand%0d_write%0d: addr=%0d data=%h x=%0d y=%0d, expected %0d/%h/%0d/%0d",
                   f, i, wr_addr[i], wr_data[i], wr_x[i], wr_y[i], i, model_colour(iter_tab[i], mx),
                   i % W, i / W);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_colour();
    test_backpressure();
    test_stall_go();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
